inst_fetch_unit: RTL and testbench

Initiator side of the instruction-memory interface. Drives the line address into InstMemory and captures the returned 128-bit line. Splits each line into four 32-bit instructions and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and restarts fetch at the new PC.

---
 rtl/inst_fetch_unit_pkg.sv | 18 +
 rtl/inst_fetch_unit_if.sv | 24 ++
 rtl/inst_fetch_unit_line_buf.sv | 33 +++
 rtl/inst_fetch_unit.sv | 89 ++++++++
 tb/tb_inst_fetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, state encoding and line-index helper for the instruction fetch unit.
package fetch_pkg;

   localparam int WORD_W         = 32;
   localparam int LINE_W         = 128;
   localparam int WORDS_PER_LINE = 4;
   localparam int LAT_CNT_W      = 3;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_t;

   function automatic logic [31:0] line_index(input logic [31:0] pc);
      return {4'b0, pc[31:4]};
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory bus, decode handshake and execute redirect seen by the fetch unit.
interface inst_fetch_unit_if;
   import fetch_pkg::*;

   logic [31:0]       mem_addr;
   logic [LINE_W-1:0] mem_line;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [WORD_W-1:0] inst;
   logic [31:0]       inst_pc;

   modport master (
      output mem_addr, inst_valid, inst, inst_pc,
      input  mem_line, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  mem_addr, inst_valid, inst, inst_pc,
      output mem_line, redirect, redirect_pc, inst_ready
   );

endinterface

// File: rtl/inst_fetch_unit_line_buf.sv
// 128-bit line capture register with a 4:1 word select.
module fetch_line_buf
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LINE_W-1:0] line_in,
   input  logic [1:0]        sel,
   output logic [WORD_W-1:0] word
);

   logic [LINE_W-1:0] line_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         line_q <= '0;
      else if (load)
         line_q <= line_in;
   end

   always_comb begin
      word = line_q[31:0];
      case (sel)
         2'd0: word = line_q[31:0];
         2'd1: word = line_q[63:32];
         2'd2: word = line_q[95:64];
         2'd3: word = line_q[127:96];
         default: word = line_q[31:0];
      endcase
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one line per FETCH, four words issued to decode, redirect restarts fetch.
//  state | meaning
//  FETCH | mem_addr held, waiting MEM_LATENCY edges for mem_line, then capture
//  ISSUE | line_buf word pc[3:2] offered to decode; leave after word 3 transfers
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_LATENCY = 1
)
(
   input  logic                clk,
   input  logic                reset,
   inst_fetch_unit_if.master   bus
);

   localparam logic [31:0]          PC_RST = RESET_PC & ~32'd3;
   localparam logic [LAT_CNT_W-1:0] LAT    = LAT_CNT_W'(MEM_LATENCY);

   state_t              state, state_nx;
   logic [31:0]         pc, pc_nx;
   logic [LAT_CNT_W-1:0] lat_cnt, lat_nx;
   logic                load;
   logic                xfer;
   logic [WORD_W-1:0]   word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= PC_RST;
         lat_cnt <= '0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         lat_cnt <= lat_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      lat_nx   = lat_cnt;
      load     = 1'b0;
      xfer     = (state == ISSUE) && bus.inst_ready;
      // Redirect wins over everything, including a same-cycle transfer and a pending capture.
      if (bus.redirect) begin
         pc_nx    = {bus.redirect_pc[31:2], 2'b00};
         state_nx = FETCH;
         lat_nx   = '0;
      end else begin
         case (state)
            FETCH: begin
               if (lat_cnt == LAT) begin
                  load     = 1'b1;
                  lat_nx   = '0;
                  state_nx = ISSUE;
               end else begin
                  lat_nx = lat_cnt + 1'b1;
               end
            end
            ISSUE: begin
               if (xfer) begin
                  pc_nx = pc + 32'd4;
                  if (pc[3:2] == 2'd3) begin
                     state_nx = FETCH;
                     lat_nx   = '0;
                  end
               end
            end
            default: state_nx = FETCH;
         endcase
      end
   end

   fetch_line_buf u_line_buf (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .line_in (bus.mem_line),
      .sel     (pc[3:2]),
      .word    (word)
   );

   assign bus.mem_addr   = line_index(pc);
   assign bus.inst_valid = (state == ISSUE);
   assign bus.inst       = (state == ISSUE) ? word : '0;
   assign bus.inst_pc    = (state == ISSUE) ? pc : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a one-edge-latency instruction memory model.
module tb_inst_fetch_unit;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   inst_fetch_unit_if bus ();

   inst_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] n, input int k);
      logic [3:0] kk;
      kk = 4'(k);
      if (n == 32'd0)
         return 32'h1111_1111 * k;
      if (n == 32'd2 && k == 2)
         return 32'hAAAA_0002;
      return {4'hB, n[23:0], kk};
   endfunction

   function automatic logic [LINE_W-1:0] mem_data(input logic [31:0] n);
      logic [LINE_W-1:0] l;
      for (int k = 0; k < 4; k++)
         l[32*k +: 32] = mem_word(n, k);
      return l;
   endfunction

   always @(posedge clk)
      bus.mem_line <= mem_data(bus.mem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input logic v, input logic [31:0] a,
                          input logic [31:0] i, input logic [31:0] p);
      chk({tag, " valid"}, {31'b0, bus.inst_valid}, {31'b0, v});
      chk({tag, " addr"}, bus.mem_addr, a);
      if (v) begin
         chk({tag, " inst"}, bus.inst, i);
         chk({tag, " pc"}, bus.inst_pc, p);
      end
   endtask

   // Leaves the bench at cycle 0: just after reset release, before the first edge.
   task automatic do_reset();
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   task automatic scen1(input string tag);
      chk_cyc({tag, " c0"}, 1'b0, 32'd0, 32'd0, 32'd0);
      next_cyc();
      chk_cyc({tag, " c1"}, 1'b0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         next_cyc();
         chk_cyc($sformatf("%s c%0d", tag, k + 2), 1'b1, 32'd0, 32'h1111_1111 * k, 32'(4 * k));
      end
      next_cyc();
      chk_cyc({tag, " c6"}, 1'b0, 32'd1, 32'd0, 32'd0);
      next_cyc();
      chk_cyc({tag, " c7"}, 1'b0, 32'd1, 32'd0, 32'd0);
      next_cyc();
      chk_cyc({tag, " c8"}, 1'b1, 32'd1, 32'hB000_0010, 32'h10);
   endtask

   initial begin
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("reset valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("reset addr", bus.mem_addr, 32'd0);
      chk("reset inst", bus.inst, 32'd0);
      chk("reset pc", bus.inst_pc, 32'd0);

      // Straight line fetch
      do_reset();
      scen1("t1");

      // Decode stall on word 1
      do_reset();
      for (int c = 0; c < 3; c++) next_cyc();
      bus.inst_ready = 1'b0;
      for (int c = 3; c <= 6; c++) begin
         chk_cyc($sformatf("t2 stall c%0d", c), 1'b1, 32'd0, 32'h1111_1111, 32'd4);
         next_cyc();
      end
      bus.inst_ready = 1'b1;
      chk_cyc("t2 c7", 1'b1, 32'd0, 32'h1111_1111, 32'd4);
      next_cyc();
      chk_cyc("t2 c8", 1'b1, 32'd0, 32'h2222_2222, 32'd8);
      next_cyc();
      chk_cyc("t2 c9", 1'b1, 32'd0, 32'h3333_3333, 32'hC);
      next_cyc();
      chk_cyc("t2 c10", 1'b0, 32'd1, 32'd0, 32'd0);

      // Redirect during ISSUE coinciding with a transfer
      do_reset();
      for (int c = 0; c < 3; c++) next_cyc();
      chk_cyc("t3 c3", 1'b1, 32'd0, 32'h1111_1111, 32'd4);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_002B;
      next_cyc();
      bus.redirect = 1'b0;
      chk_cyc("t3 c4", 1'b0, 32'd2, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t3 c5", 1'b0, 32'd2, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t3 c6", 1'b1, 32'd2, 32'hAAAA_0002, 32'h28);
      next_cyc();
      chk_cyc("t3 c7", 1'b1, 32'd2, 32'hB000_0023, 32'h2C);
      next_cyc();
      chk_cyc("t3 c8", 1'b0, 32'd3, 32'd0, 32'd0);

      // Redirect while line 1 is in flight, held for two cycles
      do_reset();
      for (int c = 0; c < 6; c++) next_cyc();
      chk_cyc("t4 c6", 1'b0, 32'd1, 32'd0, 32'd0);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_0040;
      next_cyc();
      chk_cyc("t4 c7", 1'b0, 32'd4, 32'd0, 32'd0);
      next_cyc();
      bus.redirect = 1'b0;
      chk_cyc("t4 c8", 1'b0, 32'd4, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t4 c9", 1'b0, 32'd4, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t4 c10", 1'b1, 32'd4, 32'hB000_0040, 32'h40);

      // Line index wrap at top of address space
      do_reset();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFF8;
      next_cyc();
      bus.redirect = 1'b0;
      chk_cyc("t5 c1", 1'b0, 32'h0FFF_FFFF, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t5 c2", 1'b0, 32'h0FFF_FFFF, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t5 c3", 1'b1, 32'h0FFF_FFFF, 32'hBFFF_FFF2, 32'hFFFF_FFF8);
      next_cyc();
      chk_cyc("t5 c4", 1'b1, 32'h0FFF_FFFF, 32'hBFFF_FFF3, 32'hFFFF_FFFC);
      next_cyc();
      chk_cyc("t5 c5", 1'b0, 32'd0, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t5 c6", 1'b0, 32'd0, 32'd0, 32'd0);
      next_cyc();
      chk_cyc("t5 c7", 1'b1, 32'd0, 32'd0, 32'd0);

      // Asynchronous reset between edges while issuing line 1
      do_reset();
      for (int c = 0; c < 8; c++) next_cyc();
      chk_cyc("t6 pre", 1'b1, 32'd1, 32'hB000_0010, 32'h10);
      #2;
      reset = 1'b1;
      #1;
      chk("t6 async valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("t6 async addr", bus.mem_addr, 32'd0);
      chk("t6 async pc", bus.inst_pc, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      scen1("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
